// File: rtl/drive_sequencer.sv
// Maneuver sequencer: mirrors line-follow steering and pre-empts it with timed
// brake / reverse / pivot sequences on collisions or turning junctions.
module drive_sequencer #(
  parameter int unsigned BRAKE_CYCLES   = 2_500_000,
  parameter int unsigned REVERSE_CYCLES = 25_000_000,
  parameter int unsigned PIVOT_CYCLES   = 20_000_000,
  parameter int unsigned TIMER_W        = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       colDetect,
  input  logic       juncDetect,
  input  logic [1:0] juncTurn,
  input  logic [1:0] lineDir,
  output logic [1:0] leftCmd,
  output logic [1:0] rightCmd,
  output logic       leftFast,
  output logic       rightFast,
  output logic [2:0] state,
  output logic       busy,
  output logic       maneuverDone
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FOLLOW  = 3'd1,
    S_BRAKE   = 3'd2,
    S_REVERSE = 3'd3,
    S_PIVOT   = 3'd4
  } state_t;

  localparam logic [1:0] CMD_COAST   = 2'b00;
  localparam logic [1:0] CMD_FORWARD = 2'b01;
  localparam logic [1:0] CMD_REVERSE = 2'b10;
  localparam logic [1:0] CMD_BRAKE   = 2'b11;

  localparam logic [TIMER_W-1:0] T_ZERO       = TIMER_W'(0);
  localparam logic [TIMER_W-1:0] T_ONE        = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] BRAKE_LOAD   = TIMER_W'(BRAKE_CYCLES - 32'd1);
  localparam logic [TIMER_W-1:0] REVERSE_LOAD = TIMER_W'(REVERSE_CYCLES - 32'd1);
  localparam logic [TIMER_W-1:0] PIVOT_LOAD   = TIMER_W'(PIVOT_CYCLES - 32'd1);

  state_t               state_r, state_s;
  logic [TIMER_W-1:0]   timer_r, timer_s;
  logic                 cause_r, cause_s;
  logic                 pivot_dir_r, pivot_dir_s;
  logic                 col_toggle_r, col_toggle_s;
  logic                 done_s;
  logic                 cause_eff_s;
  logic                 timer_zero_s;
  logic [1:0]           left_cmd_s, right_cmd_s;
  logic                 left_fast_s, right_fast_s;
  logic                 busy_s;

  assign timer_zero_s = (timer_r == T_ZERO);
  assign cause_eff_s  = cause_r | colDetect;
  assign state        = state_r;

  // Next-state, timer and maneuver bookkeeping
  always_comb begin
    state_s      = state_r;
    timer_s      = timer_r;
    cause_s      = cause_r;
    pivot_dir_s  = pivot_dir_r;
    col_toggle_s = col_toggle_r;
    done_s       = 1'b0;
    if (!enable) begin
      state_s = S_IDLE;
      timer_s = T_ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_s = S_FOLLOW;
          timer_s = T_ZERO;
        end
        S_FOLLOW: begin
          if (colDetect) begin
            state_s = S_BRAKE;
            cause_s = 1'b1;
            timer_s = BRAKE_LOAD;
          end else if (juncDetect && (juncTurn == 2'b01 || juncTurn == 2'b10)) begin
            state_s     = S_BRAKE;
            cause_s     = 1'b0;
            pivot_dir_s = (juncTurn == 2'b01);
            timer_s     = BRAKE_LOAD;
          end else begin
            state_s = S_FOLLOW;
          end
        end
        // A collision during a junction brake upgrades the cause without extending the brake
        S_BRAKE: begin
          cause_s = cause_eff_s;
          if (timer_zero_s) begin
            if (cause_eff_s) begin
              state_s = S_REVERSE;
              timer_s = REVERSE_LOAD;
            end else begin
              state_s = S_PIVOT;
              timer_s = PIVOT_LOAD;
            end
          end else begin
            timer_s = timer_r - T_ONE;
          end
        end
        S_REVERSE: begin
          if (timer_zero_s) begin
            state_s      = S_PIVOT;
            timer_s      = PIVOT_LOAD;
            pivot_dir_s  = col_toggle_r;
            col_toggle_s = ~col_toggle_r;
          end else begin
            timer_s = timer_r - T_ONE;
          end
        end
        S_PIVOT: begin
          if (colDetect) begin
            state_s = S_BRAKE;
            cause_s = 1'b1;
            timer_s = BRAKE_LOAD;
          end else if (timer_zero_s) begin
            state_s = S_FOLLOW;
            timer_s = T_ZERO;
            done_s  = 1'b1;
          end else begin
            timer_s = timer_r - T_ONE;
          end
        end
        default: begin
          state_s = S_IDLE;
          timer_s = T_ZERO;
        end
      endcase
    end
  end

  // Motor commands decoded from the upcoming state so they register alongside it
  always_comb begin
    left_cmd_s   = CMD_COAST;
    right_cmd_s  = CMD_COAST;
    left_fast_s  = 1'b0;
    right_fast_s = 1'b0;
    case (state_s)
      S_IDLE: begin
        left_cmd_s  = CMD_COAST;
        right_cmd_s = CMD_COAST;
      end
      S_FOLLOW: begin
        case (lineDir)
          2'b00: begin
            left_cmd_s   = CMD_FORWARD;
            right_cmd_s  = CMD_FORWARD;
            left_fast_s  = 1'b1;
            right_fast_s = 1'b1;
          end
          2'b01: begin
            left_cmd_s   = CMD_FORWARD;
            right_cmd_s  = CMD_FORWARD;
            right_fast_s = 1'b1;
          end
          2'b10: begin
            left_cmd_s  = CMD_FORWARD;
            right_cmd_s = CMD_FORWARD;
            left_fast_s = 1'b1;
          end
          default: begin
            left_cmd_s  = CMD_BRAKE;
            right_cmd_s = CMD_BRAKE;
          end
        endcase
      end
      S_BRAKE: begin
        left_cmd_s  = CMD_BRAKE;
        right_cmd_s = CMD_BRAKE;
      end
      S_REVERSE: begin
        left_cmd_s   = CMD_REVERSE;
        right_cmd_s  = CMD_REVERSE;
        left_fast_s  = 1'b1;
        right_fast_s = 1'b1;
      end
      S_PIVOT: begin
        if (pivot_dir_s) begin
          left_cmd_s  = CMD_REVERSE;
          right_cmd_s = CMD_FORWARD;
        end else begin
          left_cmd_s  = CMD_FORWARD;
          right_cmd_s = CMD_REVERSE;
        end
      end
      default: begin
        left_cmd_s  = CMD_COAST;
        right_cmd_s = CMD_COAST;
      end
    endcase
  end

  assign busy_s = (state_s == S_BRAKE) || (state_s == S_REVERSE) || (state_s == S_PIVOT);

  // State, maneuver registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      timer_r      <= T_ZERO;
      cause_r      <= 1'b0;
      pivot_dir_r  <= 1'b0;
      col_toggle_r <= 1'b0;
      leftCmd      <= CMD_COAST;
      rightCmd     <= CMD_COAST;
      leftFast     <= 1'b0;
      rightFast    <= 1'b0;
      busy         <= 1'b0;
      maneuverDone <= 1'b0;
    end else begin
      state_r      <= state_s;
      timer_r      <= timer_s;
      cause_r      <= cause_s;
      pivot_dir_r  <= pivot_dir_s;
      col_toggle_r <= col_toggle_s;
      leftCmd      <= left_cmd_s;
      rightCmd     <= right_cmd_s;
      leftFast     <= left_fast_s;
      rightFast    <= right_fast_s;
      busy         <= busy_s;
      maneuverDone <= done_s;
    end
  end

endmodule
